// File: rtl/puf_challenge_driver.sv
// Host-side initiator for a serial PUF core: accepts a challenge, clears the
// core, runs all ring oscillators until the core flags done (or the run times
// out), then hands the captured response back over a valid/ready channel.
module puf_challenge_driver #(
   parameter int unsigned CLEAR_CYCLES = 4,
   parameter int unsigned TIMEOUT      = 65535,
   parameter int unsigned TMR_W        = 16,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             chal_valid,
   output logic             chal_ready,
   input  logic [7:0]       chal_data,
   output logic [7:0]       puf_challenge,
   output logic [31:0]      puf_enable,
   output logic             puf_reset,
   input  logic [7:0]       puf_response,
   input  logic             puf_done,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [7:0]       resp_data,
   output logic             resp_err,
   output logic [CNT_W-1:0] resp_count,
   output logic             busy
);

   localparam int unsigned CHAL_W = 8;
   localparam int unsigned EN_W   = 32;
   localparam int unsigned RESP_W = 8;

   localparam logic [TMR_W-1:0] CLEAR_LAST   = TMR_W'(CLEAR_CYCLES - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CHAL_W-1:0]   chal_q, chal_d;
   logic [EN_W-1:0]     en_q, en_d;
   logic                prst_q, prst_d;
   logic                rv_q, rv_d;
   logic [RESP_W-1:0]   rd_q, rd_d;
   logic                re_q, re_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic                busy_q, busy_d;

   // Next-state and registered-output logic; the timer is shared by CLEAR and RUN
   always_comb begin
      state_d = state_q;
      chal_d  = chal_q;
      en_d    = en_q;
      prst_d  = prst_q;
      rv_d    = rv_q;
      rd_d    = rd_q;
      re_d    = re_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;

      case (state_q)
         S_IDLE: begin
            en_d   = '0;
            prst_d = 1'b1;
            if (chal_valid && chal_ready) begin
               chal_d  = chal_data;
               tmr_d   = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            en_d   = '0;
            prst_d = 1'b1;
            if (tmr_q == CLEAR_LAST) begin
               tmr_d   = '0;
               en_d    = '1;
               prst_d  = 1'b0;
               state_d = S_RUN;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_RUN: begin
            tmr_d = tmr_q + TMR_W'(1);
            // tmr_q==0 is the first RUN cycle: a done left over from a prior run is ignored
            if ((tmr_q != '0) && puf_done) begin
               rd_d    = puf_response;
               re_d    = 1'b0;
               rv_d    = 1'b1;
               en_d    = '0;
               prst_d  = 1'b1;
               state_d = S_OUT;
            end else if (tmr_q == TIMEOUT_LAST) begin
               rd_d    = '0;
               re_d    = 1'b1;
               rv_d    = 1'b1;
               en_d    = '0;
               prst_d  = 1'b1;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            en_d   = '0;
            prst_d = 1'b1;
            if (resp_ready) begin
               rv_d    = 1'b0;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         chal_q  <= '0;
         en_q    <= '0;
         prst_q  <= 1'b1;
         rv_q    <= 1'b0;
         rd_q    <= '0;
         re_q    <= 1'b0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         chal_q  <= chal_d;
         en_q    <= en_d;
         prst_q  <= prst_d;
         rv_q    <= rv_d;
         rd_q    <= rd_d;
         re_q    <= re_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         busy_q  <= busy_d;
      end
   end

   // chal_ready depends on state only, so no input-to-output path exists
   assign chal_ready    = (state_q == S_IDLE);
   assign puf_challenge = chal_q;
   assign puf_enable    = en_q;
   assign puf_reset     = prst_q;
   assign resp_valid    = rv_q;
   assign resp_data     = rd_q;
   assign resp_err      = re_q;
   assign resp_count    = cnt_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_puf_challenge_driver.sv
// Directed bench for puf_challenge_driver: instance 0 uses default parameters,
// instance 1 uses CLEAR_CYCLES=1, TIMEOUT=8, CNT_W=2 for timeout and wrap cases.
module tb_puf_challenge_driver;

   logic clk = 1'b0;
   logic rst_n;

   logic [1:0]       cv, pd, rr;
   logic [1:0][7:0]  cd, pr;
   logic [1:0]       cr, prst, rv, re, busy;
   logic [1:0][7:0]  pc, rd;
   logic [1:0][31:0] pe;
   logic [15:0]      cnt0;
   logic [1:0]       cnt1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   puf_challenge_driver u_dut0 (
      .clock(clk), .reset(rst_n),
      .chal_valid(cv[0]), .chal_ready(cr[0]), .chal_data(cd[0]),
      .puf_challenge(pc[0]), .puf_enable(pe[0]), .puf_reset(prst[0]),
      .puf_response(pr[0]), .puf_done(pd[0]),
      .resp_valid(rv[0]), .resp_ready(rr[0]), .resp_data(rd[0]),
      .resp_err(re[0]), .resp_count(cnt0), .busy(busy[0])
   );

   puf_challenge_driver #(
      .CLEAR_CYCLES(1), .TIMEOUT(8), .TMR_W(4), .CNT_W(2)
   ) u_dut1 (
      .clock(clk), .reset(rst_n),
      .chal_valid(cv[1]), .chal_ready(cr[1]), .chal_data(cd[1]),
      .puf_challenge(pc[1]), .puf_enable(pe[1]), .puf_reset(prst[1]),
      .puf_response(pr[1]), .puf_done(pd[1]),
      .resp_valid(rv[1]), .resp_ready(rr[1]), .resp_data(rd[1]),
      .resp_err(re[1]), .resp_count(cnt1), .busy(busy[1])
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cnt_of(input int s);
      return (s == 1) ? {30'b0, cnt1} : {16'b0, cnt0};
   endfunction

   task automatic chk_idle(input int s, input int cnt_exp, input string tag);
      chk({tag, "_chal_ready"}, 32'(cr[s]), 32'd1);
      chk({tag, "_busy"},       32'(busy[s]), 32'd0);
      chk({tag, "_resp_valid"}, 32'(rv[s]), 32'd0);
      chk({tag, "_enable"},     pe[s], 32'd0);
      chk({tag, "_puf_reset"},  32'(prst[s]), 32'd1);
      chk({tag, "_count"},      cnt_of(s), 32'(cnt_exp));
   endtask

   // Handshake a challenge and walk through CLEAR; returns in the first RUN cycle
   task automatic start(input int s, input logic [7:0] d, input int clr_exp, input string tag);
      int n;
      cv[s] = 1'b1;
      cd[s] = d;
      step();
      cv[s] = 1'b0;
      chk({tag, "_challenge"},  32'(pc[s]), 32'(d));
      chk({tag, "_busy"},       32'(busy[s]), 32'd1);
      chk({tag, "_chal_ready"}, 32'(cr[s]), 32'd0);
      n = 0;
      while (prst[s] === 1'b1 && pe[s] === 32'd0 && n < 50) begin
         n++;
         step();
      end
      chk({tag, "_clear_cycles"}, 32'(n), 32'(clr_exp));
      chk({tag, "_run_enable"},   pe[s], 32'hFFFF_FFFF);
      chk({tag, "_run_puf_reset"}, 32'(prst[s]), 32'd0);
   endtask

   task automatic consume(input int s, input int cnt_exp, input string tag);
      rr[s] = 1'b1;
      step();
      rr[s] = 1'b0;
      chk_idle(s, cnt_exp, tag);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      // Reset held with random inputs
      for (int k = 0; k < 3; k++) begin
         cv = 2'($urandom); pd = 2'($urandom); rr = 2'($urandom);
         cd = 16'($urandom); pr = 16'($urandom);
         step();
      end
      for (int s = 0; s < 2; s++) begin
         chk_idle(s, 0, "reset");
         chk("reset_challenge", 32'(pc[s]), 32'd0);
         chk("reset_resp_data", 32'(rd[s]), 32'd0);
         chk("reset_resp_err",  32'(re[s]), 32'd0);
      end
      cv = '0; pd = '0; rr = '0; cd = '0; pr = '0;
      step();
      rst_n = 1'b1;
      step();

      // Abort: reset mid-RUN returns to IDLE with no response
      start(0, 8'h42, 4, "abort");
      step(); step(); step();
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle(0, 0, "abort");
      chk("abort_challenge", 32'(pc[0]), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // Basic run: done 20 cycles into RUN
      start(0, 8'hA5, 4, "basic");
      repeat (19) step();
      chk("basic_no_early_valid", 32'(rv[0]), 32'd0);
      pr[0] = 8'h3C;
      pd[0] = 1'b1;
      step();
      pd[0] = 1'b0;
      chk("basic_valid",     32'(rv[0]), 32'd1);
      chk("basic_data",      32'(rd[0]), 32'h3C);
      chk("basic_err",       32'(re[0]), 32'd0);
      chk("basic_enable",    pe[0], 32'd0);
      chk("basic_puf_reset", 32'(prst[0]), 32'd1);
      chk("basic_count_pre", cnt_of(0), 32'd0);
      consume(0, 1, "basic_done");

      // Backpressure: response held, new challenge ignored
      start(0, 8'h5A, 4, "bp");
      step();
      pr[0] = 8'h81;
      pd[0] = 1'b1;
      step();
      pd[0] = 1'b0;
      pr[0] = 8'h00;
      cv[0] = 1'b1;
      cd[0] = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("bp_valid_held", 32'(rv[0]), 32'd1);
         chk("bp_data_held",  32'(rd[0]), 32'h81);
         chk("bp_chal_ready", 32'(cr[0]), 32'd0);
      end
      cv[0] = 1'b0;
      consume(0, 2, "bp_done");
      chk("bp_chal_ignored", 32'(pc[0]), 32'h5A);

      // Stale done on first RUN cycle is ignored
      start(0, 8'h11, 4, "stale");
      pr[0] = 8'hEE;
      pd[0] = 1'b1;
      step();
      pd[0] = 1'b0;
      chk("stale_ignored", 32'(rv[0]), 32'd0);
      chk("stale_still_run", pe[0], 32'hFFFF_FFFF);
      step();
      pr[0] = 8'h77;
      pd[0] = 1'b1;
      step();
      pd[0] = 1'b0;
      chk("stale_valid", 32'(rv[0]), 32'd1);
      chk("stale_data",  32'(rd[0]), 32'h77);
      consume(0, 3, "stale_done");

      // Timeout on instance 1 (TIMEOUT=8)
      start(1, 8'hC3, 1, "tmo");
      n = 0;
      while (rv[1] !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("tmo_run_cycles", 32'(n), 32'd8);
      chk("tmo_valid",  32'(rv[1]), 32'd1);
      chk("tmo_data",   32'(rd[1]), 32'd0);
      chk("tmo_err",    32'(re[1]), 32'd1);
      chk("tmo_enable", pe[1], 32'd0);
      consume(1, 1, "tmo_done");

      // Done on the timeout cycle wins
      start(1, 8'h3C, 1, "tie");
      repeat (7) step();
      chk("tie_no_early_valid", 32'(rv[1]), 32'd0);
      pr[1] = 8'h96;
      pd[1] = 1'b1;
      step();
      pd[1] = 1'b0;
      chk("tie_valid", 32'(rv[1]), 32'd1);
      chk("tie_err",   32'(re[1]), 32'd0);
      chk("tie_data",  32'(rd[1]), 32'h96);
      consume(1, 2, "tie_done");

      // Count wrap with CNT_W=2: runs 3..5 give 3, 0, 1
      for (int k = 3; k <= 5; k++) begin
         start(1, 8'(k), 1, "wrap");
         step();
         pr[1] = 8'(k * 16);
         pd[1] = 1'b1;
         step();
         pd[1] = 1'b0;
         chk("wrap_data", 32'(rd[1]), 32'(k * 16));
         consume(1, k % 4, "wrap_done");
      end
      chk("inst0_count_kept", cnt_of(0), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
